// File: rtl/st_tick_scheduler_if.sv
// Bus bundle for st_tick_scheduler. It carries the base tick, the configuration port,
// the per-channel start/stop controls, and the per-channel status outputs.
interface st_tick_scheduler_if #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int SW  = 3
);
  logic            ce_st;
  logic            cfg_we;
  logic [SW-1:0]   cfg_ch;
  logic [CW-1:0]   cfg_period;
  logic            cfg_oneshot;
  logic [NCH-1:0]  start;
  logic [NCH-1:0]  stop;
  logic [NCH-1:0]  ce_out;
  logic [NCH-1:0]  busy;
  logic [NCH-1:0]  done;
  logic            cfg_err;

  modport master (
    output ce_st, cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop,
    input  ce_out, busy, done, cfg_err
  );

  modport slave (
    input  ce_st, cfg_we, cfg_ch, cfg_period, cfg_oneshot, start, stop,
    output ce_out, busy, done, cfg_err
  );
endinterface

// File: rtl/st_tick_scheduler.sv
// Multi-channel scheduler that derives per-channel periodic or one-shot enables
// from the shared 0.1 ms base strobe ce_st.
module st_tick_scheduler #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int SW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  st_tick_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [SW:0]   NCH_W    = (SW+1)'(NCH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  state_t                  state_r    [NCH];
  state_t                  state_nx_s [NCH];
  logic [NCH-1:0][CW-1:0]  cnt_r;
  logic [NCH-1:0][CW-1:0]  cnt_nx_s;
  logic [NCH-1:0][CW-1:0]  period_r;
  logic [NCH-1:0][CW-1:0]  period_eff_s;
  logic [NCH-1:0]          oneshot_r;
  logic [NCH-1:0]          wr_ok_s;
  logic                    range_ok_s;
  logic                    wr_rej_s;

  logic [NCH-1:0]          ce_nx_s;
  logic [NCH-1:0]          busy_nx_s;
  logic [NCH-1:0]          done_nx_s;
  logic [NCH-1:0]          start_err_s;
  logic                    cfg_err_nx_s;

  logic [NCH-1:0]          ce_out_r;
  logic [NCH-1:0]          busy_r;
  logic [NCH-1:0]          done_r;
  logic                    cfg_err_r;

  // Config write decode; an accepted write is visible to a start in the same cycle.
  always_comb begin
    range_ok_s = ({1'b0, bus.cfg_ch} < NCH_W);
    wr_rej_s   = bus.cfg_we & ~range_ok_s;
    for (int i = 0; i < NCH; i++) begin
      if (bus.cfg_we && (bus.cfg_ch == SW'(i))) begin
        if (state_r[i] == ST_RUN) begin
          wr_ok_s[i] = 1'b0;
          wr_rej_s   = 1'b1;
        end else begin
          wr_ok_s[i] = 1'b1;
        end
      end else begin
        wr_ok_s[i] = 1'b0;
      end
      if (wr_ok_s[i]) begin
        period_eff_s[i] = bus.cfg_period;
      end else begin
        period_eff_s[i] = period_r[i];
      end
    end
  end

  // Per-channel FSM state register, counter and configuration storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= ST_IDLE;
      end
      cnt_r     <= '0;
      period_r  <= '0;
      oneshot_r <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= state_nx_s[i];
        cnt_r[i]   <= cnt_nx_s[i];
        if (wr_ok_s[i]) begin
          period_r[i]  <= bus.cfg_period;
          oneshot_r[i] <= bus.cfg_oneshot;
        end
      end
    end
  end

  // Next-state logic: stop wins over everything, start wins over the tick.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_nx_s[i] = state_r[i];
      cnt_nx_s[i]   = cnt_r[i];
      if (bus.stop[i]) begin
        state_nx_s[i] = ST_IDLE;
        cnt_nx_s[i]   = CNT_ZERO;
      end else begin
        case (state_r[i])
          ST_IDLE, ST_DONE: begin
            if (bus.start[i] && (period_eff_s[i] != CNT_ZERO)) begin
              state_nx_s[i] = ST_RUN;
              cnt_nx_s[i]   = period_eff_s[i];
            end else begin
              state_nx_s[i] = state_r[i];
            end
          end
          ST_RUN: begin
            if (bus.start[i]) begin
              cnt_nx_s[i] = period_r[i];
            end else if (bus.ce_st) begin
              // Reload at 1 rather than 0 so a periodic channel never drifts.
              if (cnt_r[i] == CNT_ONE) begin
                if (oneshot_r[i]) begin
                  state_nx_s[i] = ST_DONE;
                  cnt_nx_s[i]   = CNT_ZERO;
                end else begin
                  cnt_nx_s[i]   = period_r[i];
                end
              end else begin
                cnt_nx_s[i] = cnt_r[i] - CNT_ONE;
              end
            end else begin
              cnt_nx_s[i] = cnt_r[i];
            end
          end
          default: begin
            state_nx_s[i] = ST_IDLE;
            cnt_nx_s[i]   = CNT_ZERO;
          end
        endcase
      end
    end
  end

  // Output decode, computed one cycle ahead and registered below.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ce_nx_s[i]     = (state_r[i] == ST_RUN) && bus.ce_st && (cnt_r[i] == CNT_ONE)
                       && !bus.start[i] && !bus.stop[i];
      start_err_s[i] = bus.start[i] && !bus.stop[i] && (state_r[i] != ST_RUN)
                       && (period_eff_s[i] == CNT_ZERO);
      busy_nx_s[i]   = (state_nx_s[i] == ST_RUN);
      done_nx_s[i]   = (state_nx_s[i] == ST_DONE);
    end
    cfg_err_nx_s = wr_rej_s | (|start_err_s);
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_out_r  <= '0;
      busy_r    <= '0;
      done_r    <= '0;
      cfg_err_r <= 1'b0;
    end else begin
      ce_out_r  <= ce_nx_s;
      busy_r    <= busy_nx_s;
      done_r    <= done_nx_s;
      cfg_err_r <= cfg_err_nx_s;
    end
  end

  assign bus.ce_out  = ce_out_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.cfg_err = cfg_err_r;

endmodule

// File: tb/tb_st_tick_scheduler.sv
// Randomised scoreboard bench for st_tick_scheduler with a tick-countdown reference model.
module tb_st_tick_scheduler;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int SW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  st_tick_scheduler_if #(.NCH(NCH), .CW(CW), .SW(SW)) bus ();

  st_tick_scheduler #(.NCH(NCH), .CW(CW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] ce;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: each running channel counts down the ticks left until it fires.
  int   m_period [NCH];
  bit   m_os     [NCH];
  bit   m_run    [NCH];
  bit   m_done   [NCH];
  int   m_left   [NCH];

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_period[c] = 0; m_os[c] = 1'b0; m_run[c] = 1'b0; m_done[c] = 1'b0; m_left[c] = 0;
    end
  endtask

  task automatic model_step(input logic ce, input logic we, input logic [SW-1:0] ch,
                            input logic [CW-1:0] per, input logic os,
                            input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    exp_t e;
    e = '0;
    if (we) begin
      if (int'(ch) >= NCH) begin
        e.err = 1'b1;
      end else if (m_run[ch]) begin
        e.err = 1'b1;
      end else begin
        m_period[ch] = int'(per);
        m_os[ch]     = os;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (sp[c]) begin
        m_run[c] = 1'b0; m_done[c] = 1'b0;
      end else if (st[c]) begin
        if (m_period[c] == 0) e.err = 1'b1;
        else begin
          m_run[c] = 1'b1; m_done[c] = 1'b0; m_left[c] = m_period[c];
        end
      end else if (m_run[c] && ce) begin
        m_left[c] = m_left[c] - 1;
        if (m_left[c] == 0) begin
          e.ce[c] = 1'b1;
          if (m_os[c]) begin
            m_run[c] = 1'b0; m_done[c] = 1'b1;
          end else begin
            m_left[c] = m_period[c];
          end
        end
      end
      e.busy[c] = m_run[c];
      e.done[c] = m_done[c];
    end
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    bus.ce_st = 1'b0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_period = '0;
    bus.cfg_oneshot = 1'b0; bus.start = '0; bus.stop = '0;
  endtask

  task automatic do_cycle(input logic ce, input logic we, input logic [SW-1:0] ch,
                          input logic [CW-1:0] per, input logic os,
                          input logic [NCH-1:0] st, input logic [NCH-1:0] sp);
    bus.ce_st = ce; bus.cfg_we = we; bus.cfg_ch = ch; bus.cfg_period = per;
    bus.cfg_oneshot = os; bus.start = st; bus.stop = sp;
    model_step(ce, we, ch, per, os, st, sp);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      do_cycle(1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);
      idle(2);
    end
  endtask

  task automatic cfg(input logic [SW-1:0] ch, input logic [CW-1:0] per, input logic os);
    do_cycle(1'b0, 1'b1, ch, per, os, 4'b0000, 4'b0000);
  endtask

  task automatic go(input logic [NCH-1:0] st);
    do_cycle(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, st, 4'b0000);
  endtask

  // Asynchronous reset in the middle of a clock period while channel 0 runs.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    check("busy_before_rst", 32'(bus.busy[0]), 32'(m_run[0]));
    rst = 1'b1;
    #1;
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_ce_out",  32'(bus.ce_out),  32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compares every registered output against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("ce_out",  32'(bus.ce_out),  32'(mon_e.ce));
      check("busy",    32'(bus.busy),    32'(mon_e.busy));
      check("done",    32'(bus.done),    32'(mon_e.done));
      check("cfg_err", 32'(bus.cfg_err), 32'(mon_e.err));
    end
  end

  initial begin
    logic [NCH-1:0] st_r;
    logic [NCH-1:0] sp_r;
    clear_inputs();
    model_reset();
    #5;
    check("init_busy",    32'(bus.busy),    32'd0);
    check("init_ce_out",  32'(bus.ce_out),  32'd0);
    check("init_done",    32'(bus.done),    32'd0);
    check("init_cfg_err", 32'(bus.cfg_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Start with period 0 is rejected and the channel stays idle.
    go(4'b0100);
    idle(1);

    // Periodic channel, interrupted by an asynchronous reset.
    cfg(3'd0, 16'd3, 1'b0);
    go(4'b0001);
    ticks(4);
    mid_reset();
    ticks(4);

    // Periodic ch0 period 3: pulses after ticks 3, 6, 9.
    cfg(3'd0, 16'd3, 1'b0);
    go(4'b0001);
    ticks(9);

    // One-shot ch1 period 2, then a restart clears done.
    cfg(3'd1, 16'd2, 1'b1);
    go(4'b0010);
    ticks(3);
    go(4'b0010);
    ticks(1);
    do_cycle(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0010);

    // Start coincident with a tick: that tick is not counted.
    do_cycle(1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0001, 4'b0000);
    ticks(4);

    // Stop coincident with the terminal tick suppresses the pulse.
    cfg(3'd3, 16'd1, 1'b0);
    go(4'b1000);
    do_cycle(1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b1000);
    idle(1);

    // Rejected writes: channel in RUN and out-of-range index.
    cfg(3'd0, 16'd7, 1'b0);
    ticks(3);
    cfg(3'd5, 16'd2, 1'b0);
    idle(1);

    // Write and start on the same idle channel: start uses the new period.
    do_cycle(1'b0, 1'b1, 3'd2, 16'd4, 1'b0, 4'b0100, 4'b0000);
    ticks(4);

    // Concurrency: ch0 period 1 and ch2 period 4.
    do_cycle(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 4'b0000, 4'b0001);
    cfg(3'd0, 16'd1, 1'b0);
    go(4'b0101);
    ticks(8);

    // Randomised traffic.
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        st_r[c] = ($urandom_range(0, 15) == 0);
        sp_r[c] = ($urandom_range(0, 31) == 0);
      end
      do_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
               SW'($urandom_range(0, 7)), CW'($urandom_range(0, 5)),
               1'($urandom_range(0, 1)), st_r, sp_r);
    end

    idle(2);
    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
